cpu_ctrl_mc: RTL and testbench
==============================

// Module: cpu_ctrl_mc
// PURPOSE
//  Parametrised multi-cycle control FSM for the bitty datapath. Decodes the
//  16-bit instruction on d_inst and sequences the register-file, ALU and
//  instruction-register enables.
//  Supports four formats: reg-reg ALU, reg-imm ALU, NOP, and load/store.
//  Load/store uses a req/ack memory handshake with a timeout.
//  Drives the source mux, ALU select, register enables and done/busy flags.
// PARAMETERS
//  DATA_W       16  width of im_d (immediate bus)
//  REG_COUNT     8  number of GP registers, 2..8; rd/rs fields stay 3 bits
//  MEM_TIMEOUT  15  MEM-state cycles without mem_ack before abort, >=1
//  MUX_W   derived  localparam $clog2(REG_COUNT+3); value 4 at defaults
// PORTS
//  clk       in   1          clock, rising edge
//  reset     in   1          synchronous, active-high
//  run       in   1          start one instruction; sampled in IDLE only
//  d_inst    in   16         instruction; must be held stable while busy=1
//  mem_ack   in   1          memory completes the request
//  mux_sel   out  MUX_W      bus source: 0..REG_COUNT-1=reg, REG_COUNT=IMM,
//                            REG_COUNT+1=DEF, REG_COUNT+2=MEM
//  sel       out  3          ALU op
//  en_s      out  1          load source/operand register
//  en_c      out  1          load ALU result register
//  en        out  REG_COUNT  one-hot register write enable
//  en_inst   out  1          instruction-register load enable
//  im_d      out  DATA_W     immediate
//  mem_req   out  1          memory request
//  mem_we    out  1          1=store, 0=load; valid while mem_req=1
//  done      out  1          one-cycle pulse, instruction complete
//  busy      out  1          state != IDLE
//  err       out  1          sticky memory-timeout flag
// BEHAVIOUR
//  Fields: rd=d_inst[15:13], rs=d_inst[12:10], imm8=d_inst[12:5],
//   op=d_inst[4:2], st=d_inst[4], fmt=d_inst[1:0].
//   fmt 00=ALU rr, 01=ALU ri, 10=NOP, 11=LD/ST.
//  Output timing: outputs are combinational decodes of state and d_inst.
//   Defaults: en_s=en_c=mem_req=mem_we=done=0; en=0; sel=0; mux_sel=DEF;
//   en_inst=1 in IDLE/DONE, 0 elsewhere.
//  Reset: state<=IDLE, err<=0, timeout counter<=0. All outputs then hold
//   their defaults; busy=0; reset wins over every other event.
//  IDLE: if run=1, go to OPA.
//  OPA: fmt00/01 -> en_s=1, mux_sel=rd, go to OPB.
//   fmt11 -> en_s=1, mux_sel=rs (address), go to MEM.
//   fmt10 -> go to DONE.
//  OPB: en_c=1, sel=op; mux_sel=rs (fmt00) or IMM (fmt01); go to WB.
//  WB: en[rd]=1, go to DONE.
//  MEM: mem_req=1, mem_we=st; mux_sel=rd for a store, MEM for a load.
//   mem_ack=1: a load also asserts en[rd]=1 in the same cycle; go to DONE.
//   No ack within MEM_TIMEOUT MEM cycles: err<=1, no write, go to DONE.
//   If the ack arrives in the last allowed cycle, the ack wins and no error
//   is raised.
//  DONE: done=1, go to IDLE. run is ignored in DONE.
//  Latency from the run-sampling edge to the done cycle:
//   fmt00/01: 4 cycles. fmt10: 2 cycles.
//   fmt11: 2 + (number of MEM cycles).
//  err: cleared when run is accepted in IDLE; otherwise held until reset.
//  rd >= REG_COUNT: en stays 0 (write suppressed); everything else is
//   unchanged.
//  im_d = zero-extended imm8 in every state.
// CONFIGURATION
//  SIGN_EXT_EN defined: im_d = imm8 sign-extended to DATA_W, using
//   imm8[7] as the sign bit.
//  SIGN_EXT_EN undefined: im_d = {(DATA_W-8)'b0, imm8}.
// TESTING (defaults)
//  1. d_inst=16'h2800, run pulse -> OPA: en_s=1, mux_sel=1; OPB: en_c=1,
//     mux_sel=2, sel=0; WB: en=8'h02; done in the 4th cycle; en_inst=0
//     in OPA..WB.
//  2. d_inst=16'h7E15 -> im_d=16'h00F0 (16'hFFF0 with SIGN_EXT_EN);
//     OPB: mux_sel=8, sel=5; WB: en=8'h08.
//  3. d_inst=16'h0002 -> no en_s/en_c/en pulse; done 2 cycles after run.
//  4. Load 16'h9403, mem_ack on the 3rd MEM cycle -> mem_we=0, mux_sel=10,
//     en=8'h10 in the ack cycle. Store 16'h9413 -> mem_we=1, mux_sel=4,
//     en=0.
//  5. Load, no ack -> 15 MEM cycles, then err=1 with done=1 and en=0.
//     Next run accepted -> err=0.
//  6. reset=1 in the 2nd MEM cycle -> next cycle IDLE: mem_req=0,
//     en_inst=1, busy=0, err=0, mux_sel=9.

Source files
------------

// File: rtl/cpu_ctrl_mc.sv
// Multi-cycle control FSM for the bitty datapath: decodes d_inst and sequences operand, ALU, writeback and memory steps.
// Optional build macro SIGN_EXT_EN: sign-extend imm8 onto im_d instead of zero-extending it.
module cpu_ctrl_mc #(
  parameter int DATA_W      = 16,
  parameter int REG_COUNT   = 8,
  parameter int MEM_TIMEOUT = 15,
  localparam int MUX_W      = $clog2(REG_COUNT + 3)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [15:0]          d_inst,
  input  logic                 mem_ack,
  output logic [MUX_W-1:0]     mux_sel,
  output logic [2:0]           sel,
  output logic                 en_s,
  output logic                 en_c,
  output logic [REG_COUNT-1:0] en,
  output logic                 en_inst,
  output logic [DATA_W-1:0]    im_d,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           state_dbg
);

  // Memory handshake: mem_req stays high through every MEM cycle; the
  // request completes in the first cycle where mem_req=1 and mem_ack=1.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPA  = 3'd1,
    OPB  = 3'd2,
    WB   = 3'd3,
    MEM  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [MUX_W-1:0] SEL_IMM = MUX_W'(REG_COUNT);
  localparam logic [MUX_W-1:0] SEL_DEF = MUX_W'(REG_COUNT + 1);
  localparam logic [MUX_W-1:0] SEL_MEM = MUX_W'(REG_COUNT + 2);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           rd, rs, op;
  logic [7:0]           imm8;
  logic                 st;
  logic [1:0]           fmt;
  logic [REG_COUNT-1:0] wr_onehot;
  logic                 mem_timeout;

  assign rd   = d_inst[15:13];
  assign rs   = d_inst[12:10];
  assign imm8 = d_inst[12:5];
  assign op   = d_inst[4:2];
  assign st   = d_inst[4];
  assign fmt  = d_inst[1:0];

  // Destinations beyond the implemented register count never get a write strobe.
  assign wr_onehot = (int'(rd) < REG_COUNT) ? (REG_COUNT'(1) << rd) : '0;

`ifdef SIGN_EXT_EN
  assign im_d = {{(DATA_W-8){imm8[7]}}, imm8};
`else
  assign im_d = {{(DATA_W-8){1'b0}}, imm8};
`endif

  // An ack in the final allowed MEM cycle beats the timeout.
  assign mem_timeout = (state == MEM) && !mem_ack && (cnt == LAST);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == MEM && state_n == MEM) ? cnt + CNT_W'(1) : '0;
      if (state == IDLE && run) err <= 1'b0;
      else if (mem_timeout)     err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    mux_sel = SEL_DEF;
    sel     = 3'd0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    en      = '0;
    en_inst = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        en_inst = 1'b1;
        if (run) state_n = OPA;
      end
      OPA: begin
        case (fmt)
          2'b00, 2'b01: begin
            en_s    = 1'b1;
            mux_sel = MUX_W'(rd);
            state_n = OPB;
          end
          2'b11: begin
            en_s    = 1'b1;
            mux_sel = MUX_W'(rs);
            state_n = MEM;
          end
          default: state_n = DONE;
        endcase
      end
      OPB: begin
        en_c    = 1'b1;
        sel     = op;
        mux_sel = (fmt == 2'b00) ? MUX_W'(rs) : SEL_IMM;
        state_n = WB;
      end
      WB: begin
        en      = wr_onehot;
        state_n = DONE;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = st;
        mux_sel = st ? MUX_W'(rd) : SEL_MEM;
        if (mem_ack) begin
          if (!st) en = wr_onehot;
          state_n = DONE;
        end else if (cnt == LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        en_inst = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_mc.sv
// Self-checking bench for cpu_ctrl_mc: directed vector table, reset corner cases and random instructions
// checked cycle by cycle against a trace model built from the instruction's format and ack timing.
module tb_cpu_ctrl_mc;
  localparam int TIMEOUT = 15;
  localparam int PH_IDLE = 0, PH_OPA = 1, PH_OPB = 2, PH_WB = 3, PH_MEM = 4, PH_DONE = 5;

  logic        clk = 1'b0;
  logic        reset, run, mem_ack;
  logic [15:0] d_inst;
  logic [3:0]  mux_sel;
  logic [2:0]  sel;
  logic        en_s, en_c, en_inst, mem_req, mem_we, done, busy, err;
  logic [7:0]  en;
  logic [15:0] im_d;
  logic [2:0]  state_dbg;
  logic [38:0] act;

  int   n_checks = 0;
  int   n_errors = 0;
  logic err_m    = 1'b0;

  cpu_ctrl_mc #(.DATA_W(16), .REG_COUNT(8), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .d_inst(d_inst), .mem_ack(mem_ack),
    .mux_sel(mux_sel), .sel(sel), .en_s(en_s), .en_c(en_c), .en(en), .en_inst(en_inst),
    .im_d(im_d), .mem_req(mem_req), .mem_we(mem_we), .done(done), .busy(busy), .err(err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign act = {mux_sel, sel, en_s, en_c, en, en_inst, im_d, mem_req, mem_we, done, busy, err};

  typedef struct {
    logic [15:0] inst;
    int          ack_at;   // MEM cycle carrying mem_ack, 0 = never
    logic [7:0]  exp_en;   // OR of en over the instruction
    int          exp_lat;  // cycles from run-sampling edge to done
    logic        exp_err;
    logic [15:0] exp_im;
  } vec_t;

  task automatic chk(input string name, input logic [38:0] a, input logic [38:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (mux,sel,es,ec,en,ei,im,req,we,done,busy,err) t=%0t",
               name, a, e, $time);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d t=%0t", name, a, e, $time);
    end
  endtask

  function automatic logic [38:0] expv(input logic [15:0] inst, input int ph, input logic ack,
                                       input logic e);
    logic [3:0]  mux;
    logic [2:0]  sl;
    logic        es, ec, ei, mr, mw, dn, bs;
    logic [7:0]  enx, oh;
    logic [15:0] im;
    logic [2:0]  rd;
    logic [1:0]  fmt;
    rd  = inst[15:13];
    fmt = inst[1:0];
    oh  = 8'(1) << rd;
`ifdef SIGN_EXT_EN
    im = {{8{inst[12]}}, inst[12:5]};
`else
    im = {8'h00, inst[12:5]};
`endif
    mux = 4'd9; sl = 3'd0; es = 0; ec = 0; ei = 0; mr = 0; mw = 0; dn = 0; bs = 1; enx = 8'h00;
    case (ph)
      PH_IDLE: begin ei = 1; bs = 0; end
      PH_OPA: if (fmt != 2'b10) begin
        es  = 1;
        mux = (fmt == 2'b11) ? {1'b0, inst[12:10]} : {1'b0, rd};
      end
      PH_OPB: begin
        ec = 1; sl = inst[4:2];
        mux = (fmt == 2'b00) ? {1'b0, inst[12:10]} : 4'd8;
      end
      PH_WB: enx = oh;
      PH_MEM: begin
        mr = 1; mw = inst[4];
        mux = inst[4] ? {1'b0, rd} : 4'd10;
        if (ack && !inst[4]) enx = oh;
      end
      PH_DONE: begin dn = 1; ei = 1; end
      default: ;
    endcase
    return {mux, sl, es, ec, enx, ei, im, mr, mw, dn, bs, e};
  endfunction

  // One full instruction: IDLE cycle with run, then every busy cycle checked.
  task automatic run_instr(input logic [15:0] inst, input int ack_at, input string tag,
                           output logic [7:0] en_seen, output int lat, output logic err_done,
                           output logic [15:0] im_seen);
    int n_mem, total, ph, m;
    logic [1:0] fmt;
    fmt     = inst[1:0];
    n_mem   = (fmt == 2'b11) ? ((ack_at > 0) ? ack_at : TIMEOUT) : 0;
    total   = (fmt[1] == 1'b0) ? 4 : (fmt == 2'b10) ? 2 : 2 + n_mem;
    en_seen = 8'h00; lat = 0; err_done = 1'b0;
    @(negedge clk);
    d_inst = inst; run = 1'b1; mem_ack = 1'b0;
    #1;
    im_seen = im_d;
    chk({tag, "_idle"}, act, expv(inst, PH_IDLE, 1'b0, err_m));
    err_m = 1'b0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      m   = k - 1;
      if (k == 1) ph = PH_OPA;
      else if (k == total) ph = PH_DONE;
      else if (fmt == 2'b11) ph = PH_MEM;
      else ph = k;
      mem_ack = (ph == PH_MEM && ack_at > 0 && m == ack_at);
      if (ph == PH_DONE && fmt == 2'b11 && ack_at == 0) err_m = 1'b1;
      #1;
      chk($sformatf("%s_c%0d", tag, k), act, expv(inst, ph, mem_ack, err_m));
      en_seen |= en;
      if (done && lat == 0) lat = k;
      if (done) err_done = err;
    end
    mem_ack = 1'b0;
  endtask

  vec_t        vecs[8];
  logic [7:0]  en_seen;
  int          lat;
  logic        err_done;
  logic [15:0] im_seen;
  logic [15:0] ri;
  int          ra;

  initial begin
`ifdef SIGN_EXT_EN
    vecs[0] = '{16'h2800, 0, 8'h02, 4, 1'b0, 16'h0040};
    vecs[1] = '{16'h7E15, 0, 8'h08, 4, 1'b0, 16'hFFF0};
    vecs[3] = '{16'h9403, 3, 8'h10, 5, 1'b0, 16'hFFA0};
    vecs[4] = '{16'h9413, 2, 8'h00, 4, 1'b0, 16'hFFA0};
    vecs[5] = '{16'h9403, 0, 8'h00, 17, 1'b1, 16'hFFA0};
    vecs[6] = '{16'h9403, 15, 8'h10, 17, 1'b0, 16'hFFA0};
`else
    vecs[0] = '{16'h2800, 0, 8'h02, 4, 1'b0, 16'h0040};
    vecs[1] = '{16'h7E15, 0, 8'h08, 4, 1'b0, 16'h00F0};
    vecs[3] = '{16'h9403, 3, 8'h10, 5, 1'b0, 16'h00A0};
    vecs[4] = '{16'h9413, 2, 8'h00, 4, 1'b0, 16'h00A0};
    vecs[5] = '{16'h9403, 0, 8'h00, 17, 1'b1, 16'h00A0};
    vecs[6] = '{16'h9403, 15, 8'h10, 17, 1'b0, 16'h00A0};
`endif
    vecs[2] = '{16'h0002, 0, 8'h00, 2, 1'b0, 16'h0000};
    vecs[7] = '{16'hE000, 0, 8'h80, 4, 1'b0, 16'h0000};

    reset = 1'b1; run = 1'b0; d_inst = 16'h0000; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", act, expv(16'h0000, PH_IDLE, 1'b0, 1'b0));

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].inst, vecs[i].ack_at, $sformatf("vec%0d", i), en_seen, lat, err_done, im_seen);
      chk_int($sformatf("vec%0d_en", i), int'(en_seen), int'(vecs[i].exp_en));
      chk_int($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk_int($sformatf("vec%0d_err", i), int'(err_done), int'(vecs[i].exp_err));
      chk_int($sformatf("vec%0d_im", i), int'(im_seen), int'(vecs[i].exp_im));
    end

    // Reset mid-MEM, with a simultaneous ack that reset must override.
    run_instr(16'h9403, 0, "pre_rst", en_seen, lat, err_done, im_seen);
    @(negedge clk); d_inst = 16'h9403; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1; mem_ack = 1'b1;
    #1;
    chk_int("rst_mem_req_before", int'(mem_req), 1);
    @(negedge clk); reset = 1'b0; mem_ack = 1'b0; err_m = 1'b0;
    #1;
    chk("rst_mid_mem", act, expv(16'h9403, PH_IDLE, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    chk("rst_stays_idle", act, expv(16'h9403, PH_IDLE, 1'b0, 1'b0));

    // Reset alone in IDLE clears a sticky timeout error.
    run_instr(16'h9403, 0, "pre_rst2", en_seen, lat, err_done, im_seen);
    @(negedge clk); run = 1'b0;
    #1;
    chk_int("err_sticky_idle", int'(err), 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; err_m = 1'b0;
    #1;
    chk_int("err_cleared_by_reset", int'(err), 0);

    for (int i = 0; i < 60; i++) begin
      ri = 16'($urandom);
      ra = (ri[1:0] == 2'b11 && $urandom_range(0, 3) != 0) ? $urandom_range(1, TIMEOUT) : 0;
      run_instr(ri, ra, $sformatf("rnd%0d", i), en_seen, lat, err_done, im_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
